// File: rtl/prelude_pkg.sv
// Shared types for the Prelude program-memory loader.
// Stream frame: one length byte L (0 means 256), L payload bytes, then the XOR of the payload.
package prelude_pkg;

  localparam int PROG_ADDR_W = 8;
  localparam int PROG_DATA_W = 8;
  localparam int PROG_DEPTH  = 1 << PROG_ADDR_W;

  typedef enum logic [2:0] {
    EMPTY,
    RUN,
    HDR,
    DATA,
    CSUM,
    REL,
    ERR
  } loader_state_t;

endpackage

// File: rtl/prelude_prog_ram.sv
// Program RAM with one synchronous write port and one asynchronous read port.
// Storage is not reset; a write is visible on the read port the cycle after the write edge.
module prelude_prog_ram
  import prelude_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int DATA_W = PROG_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prelude_loader.sv
// Loads a length/payload/XOR-checksum byte stream into program RAM and holds the CPU until it verifies.
// Fetch reads are combinational; the stream port is ready only while a load is in progress.
module prelude_loader
  import prelude_pkg::*;
#(
  parameter int ADDR_W  = PROG_ADDR_W,
  parameter int DATA_W  = PROG_DATA_W,
  parameter int TIMEOUT = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_req,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [DATA_W-1:0] o_fetch_data,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_load_ok,
  output logic              o_load_err,
  output logic [ADDR_W:0]   o_loaded_len
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  loader_state_t     r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_loaded_len;
  logic [DATA_W-1:0] r_csum;
  logic [TMO_W-1:0]  r_tmo;

  logic              w_busy;
  logic              w_xfer;
  logic              w_last_data;
  logic              w_tmo_hit;
  logic [ADDR_W:0]   w_hdr_len;

  assign w_busy      = (r_state == HDR) || (r_state == DATA) || (r_state == CSUM);
  assign w_xfer      = i_in_valid & w_busy;
  assign w_last_data = ((r_cnt + (ADDR_W+1)'(1)) == r_len);
  assign w_tmo_hit   = w_busy & ~w_xfer & (r_tmo == TMO_W'(TIMEOUT - 1));
  // A zero length byte encodes a full-depth image.
  assign w_hdr_len   = (i_in_data == '0) ? (ADDR_W+1)'(2**ADDR_W) : (ADDR_W+1)'(i_in_data);

  assign o_in_ready   = w_busy;
  assign o_busy       = w_busy;
  assign o_loaded_len = r_loaded_len;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= EMPTY;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_cpu_hold = 1'b1;
    o_load_ok  = 1'b0;
    o_load_err = 1'b0;
    case (r_state)
      EMPTY: if (i_load_req) w_next = HDR;
      RUN: begin
        o_cpu_hold = 1'b0;
        if (i_load_req) w_next = HDR;
      end
      HDR:  if (w_xfer) w_next = DATA;
      DATA: if (w_xfer && w_last_data) w_next = CSUM;
      CSUM: if (w_xfer) w_next = (i_in_data == r_csum) ? REL : ERR;
      // Held for this cycle so the core leaves reset with pc at 0.
      REL: begin
        o_load_ok = 1'b1;
        w_next    = RUN;
      end
      ERR: begin
        o_load_err = 1'b1;
        if (i_load_req) w_next = HDR;
      end
      default: w_next = EMPTY;
    endcase
    if (w_tmo_hit) w_next = ERR;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr       <= '0;
      r_cnt        <= '0;
      r_len        <= '0;
      r_csum       <= '0;
      r_tmo        <= '0;
      r_loaded_len <= '0;
    end else begin
      if (w_busy && !w_xfer) r_tmo <= r_tmo + TMO_W'(1);
      else                   r_tmo <= '0;
      if (w_xfer) begin
        case (r_state)
          HDR: begin
            r_len  <= w_hdr_len;
            r_addr <= '0;
            r_cnt  <= '0;
            r_csum <= '0;
          end
          DATA: begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt + (ADDR_W+1)'(1);
            r_csum <= r_csum ^ i_in_data;
          end
          CSUM: if (i_in_data == r_csum) r_loaded_len <= r_len;
          default: ;
        endcase
      end
    end
  end

  prelude_prog_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (w_xfer && (r_state == DATA)),
    .i_waddr(r_addr),
    .i_wdata(i_in_data),
    .i_raddr(i_fetch_addr),
    .o_rdata(o_fetch_data)
  );

endmodule

// File: tb/tb_prelude_loader.sv
// Randomized bench for prelude_loader against a frame-level memory/checksum model.
module tb_prelude_loader;
  import prelude_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_load_req = 1'b0;
  logic       i_in_valid = 1'b0;
  logic [7:0] i_in_data = 8'h00;
  logic       o_in_ready;
  logic [7:0] i_fetch_addr = 8'h00;
  logic [7:0] o_fetch_data;
  logic       o_cpu_hold, o_busy, o_load_ok, o_load_err;
  logic [8:0] o_loaded_len;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [PROG_DEPTH];
  bit         ref_vld [PROG_DEPTH];
  int         exp_len = 0;
  logic [7:0] pl [$];

  prelude_loader #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load_req(i_load_req),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .i_fetch_addr(i_fetch_addr), .o_fetch_data(o_fetch_data),
    .o_cpu_hold(o_cpu_hold), .o_busy(o_busy), .o_load_ok(o_load_ok),
    .o_load_err(o_load_err), .o_loaded_len(o_loaded_len)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic push(input logic [7:0] b, input int gap, input bit req);
    int waited;
    repeat (gap) @(negedge i_clk);
    i_in_valid = 1'b1;
    i_in_data  = b;
    waited = 0;
    while (!o_in_ready && waited < 40) begin
      @(negedge i_clk);
      waited++;
    end
    chk("push_rdy", 32'(o_in_ready), 32'd1);
    i_load_req = req;
    @(negedge i_clk);
    i_in_valid = 1'b0;
    i_load_req = 1'b0;
  endtask

  task automatic start_load();
    i_load_req = 1'b1;
    @(negedge i_clk);
    i_load_req = 1'b0;
    chk("start_busy", 32'(o_busy), 32'd1);
    chk("start_rdy", 32'(o_in_ready), 32'd1);
    chk("start_hold", 32'(o_cpu_hold), 32'd1);
    chk("start_err", 32'(o_load_err), 32'd0);
  endtask

  task automatic run_load(input int n, input logic [7:0] c, input bit req_at_csum,
                          input bit mid_req);
    logic [7:0] x;
    bit good;
    i_fetch_addr = 8'h00;
    start_load();
    push(8'(n % 256), $urandom_range(0, 3), 1'b0);
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (mid_req && $urandom_range(0, 7) == 0) begin
        i_load_req = 1'b1;
        @(negedge i_clk);
        i_load_req = 1'b0;
        chk("midreq_busy", 32'(o_busy), 32'd1);
      end
      push(pl[i], $urandom_range(0, 3), 1'b0);
      ref_mem[i % 256] = pl[i];
      ref_vld[i % 256] = 1'b1;
      x ^= pl[i];
      if (i == 0) chk("first_wr", 32'(o_fetch_data), 32'(pl[0]));
    end
    good = (c == x);
    push(c, $urandom_range(0, 3), req_at_csum);
    if (good) begin
      exp_len = n;
      chk("rel_ok", 32'(o_load_ok), 32'd1);
      chk("rel_hold", 32'(o_cpu_hold), 32'd1);
      chk("rel_busy", 32'(o_busy), 32'd0);
      @(negedge i_clk);
      chk("run_hold", 32'(o_cpu_hold), 32'd0);
      chk("run_ok", 32'(o_load_ok), 32'd0);
      chk("run_busy", 32'(o_busy), 32'd0);
      chk("run_len", 32'(o_loaded_len), 32'(exp_len));
    end else begin
      chk("err_flag", 32'(o_load_err), 32'd1);
      chk("err_hold", 32'(o_cpu_hold), 32'd1);
      chk("err_rdy", 32'(o_in_ready), 32'd0);
      @(negedge i_clk);
      chk("err_sticky", 32'(o_load_err), 32'd1);
      chk("err_len", 32'(o_loaded_len), 32'(exp_len));
    end
  endtask

  task automatic verify_mem();
    for (int a = 0; a < PROG_DEPTH; a++) begin
      if (ref_vld[a]) begin
        i_fetch_addr = 8'(a);
        #1;
        chk("fetch", 32'(o_fetch_data), 32'(ref_mem[a]));
      end
    end
    @(negedge i_clk);
  endtask

  task automatic rand_payload(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hold"}, 32'(o_cpu_hold), 32'd1);
    chk({tag, "_rdy"}, 32'(o_in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_ok"}, 32'(o_load_ok), 32'd0);
    chk({tag, "_err"}, 32'(o_load_err), 32'd0);
    chk({tag, "_len"}, 32'(o_loaded_len), 32'(exp_len));
  endtask

  initial begin
    int n;
    logic [7:0] x;
    for (int a = 0; a < PROG_DEPTH; a++) begin
      ref_mem[a] = 8'h00;
      ref_vld[a] = 1'b0;
    end
    repeat (3) @(negedge i_clk);
    check_reset_outputs("rst");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // T1: stream bytes offered while EMPTY are not taken
    i_in_valid = 1'b1;
    i_in_data  = 8'hAA;
    repeat (4) begin
      @(negedge i_clk);
      chk("t1_rdy", 32'(o_in_ready), 32'd0);
    end
    i_in_valid = 1'b0;
    check_reset_outputs("t1");

    // T2: known good stream
    pl = '{8'hB1, 8'h8A, 8'h44};
    run_load(3, 8'h7F, 1'b0, 1'b0);
    verify_mem();

    // T3: bad checksum, then recovery
    pl = '{8'hB1, 8'h8A, 8'h44};
    run_load(3, 8'h00, 1'b0, 1'b0);
    chk("t3_hold", 32'(o_cpu_hold), 32'd1);
    rand_payload(5);
    x = 8'h00;
    foreach (pl[i]) x ^= pl[i];
    run_load(5, x, 1'b0, 1'b0);
    verify_mem();

    // T4: full 256-byte image
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    run_load(256, 8'h00, 1'b0, 1'b0);
    verify_mem();

    // Random loads with backpressure, ignored load_req and occasional bad checksums
    repeat (10) begin
      n = $urandom_range(1, 48);
      rand_payload(n);
      x = 8'h00;
      foreach (pl[i]) x ^= pl[i];
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      run_load(n, x, 1'($urandom_range(0, 1)), 1'b1);
    end
    verify_mem();

    // T5: idle timeout mid-DATA
    start_load();
    push(8'd6, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      x = 8'($urandom_range(0, 255));
      push(x, 0, 1'b0);
      ref_mem[i] = x;
      ref_vld[i] = 1'b1;
    end
    repeat (15) @(negedge i_clk);
    chk("t5_still_busy", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    chk("t5_err", 32'(o_load_err), 32'd1);
    chk("t5_busy", 32'(o_busy), 32'd0);
    i_in_valid = 1'b1;
    i_in_data  = 8'hEE;
    repeat (5) begin
      chk("t5_rdy", 32'(o_in_ready), 32'd0);
      @(negedge i_clk);
    end
    i_in_valid = 1'b0;
    chk("t5_sticky", 32'(o_load_err), 32'd1);
    verify_mem();

    // T6: reset in the middle of DATA
    rand_payload(10);
    start_load();
    push(8'd10, $urandom_range(0, 3), 1'b0);
    for (int i = 0; i < 4; i++) begin
      push(pl[i], $urandom_range(0, 3), 1'b0);
      ref_mem[i] = pl[i];
      ref_vld[i] = 1'b1;
    end
    i_in_valid = 1'b1;
    i_rst_n = 1'b0;
    exp_len = 0;
    #1;
    check_reset_outputs("t6");
    repeat (4) begin
      @(negedge i_clk);
      i_in_valid = ~i_in_valid;
      chk("t6_rdy", 32'(o_in_ready), 32'd0);
    end
    i_in_valid = 1'b0;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_reset_outputs("t6_post");
    n = $urandom_range(1, 40);
    rand_payload(n);
    x = 8'h00;
    foreach (pl[i]) x ^= pl[i];
    run_load(n, x, 1'b0, 1'b0);
    verify_mem();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
